mips_wb_queue: RTL and testbench

Write-back queue driving the single write port of the MIPS register file (`RegWrite`, `WriteAddress`, `DataIn`). It accepts results from two producers:
- the single-cycle ALU path;
- the multi-cycle load / mult-div path.

It buffers up to DEPTH results in order and retires one per cycle into the register file. It also reports read-after-write hazards to decode for any register with a write still in flight.

---
 rtl/mips_pkg.sv | 15 +
 rtl/mips_wb_fifo.sv | 81 ++++++++
 rtl/mips_wb_queue.sv | 108 ++++++++++
 tb/tb_mips_wb_queue.sv | 261 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/mips_pkg.sv
// Shared MIPS types used by the register file, decode and write-back queue.
package mips_pkg;

   typedef logic [4:0]  reg_addr_t;
   typedef logic [31:0] word_t;

   typedef struct packed {
      reg_addr_t addr;
      word_t     data;
   } wb_entry_t;

   // Register 0 is hard-wired to zero; writes to it are discarded.
   localparam reg_addr_t REG_ZERO = 5'd0;

endpackage

// File: rtl/mips_wb_fifo.sv
// Synchronous FIFO of pending register-file writes.
// Exposes the valid/addr view of every slot so the owner can run hazard compares.
module mips_wb_fifo
   import mips_pkg::*;
#(
   parameter  int DEPTH = 4,
   localparam int PW    = $clog2(DEPTH),
   localparam int CW    = $clog2(DEPTH + 1)
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             push_i,
   input  wb_entry_t        push_entry_i,
   input  logic             pop_i,
   output wb_entry_t        head_o,
   output logic [CW-1:0]    count_o,
   output logic             full_o,
   output logic [DEPTH-1:0] entry_valid_o,
   output reg_addr_t        entry_addr_o [DEPTH]
);

   wb_entry_t     mem_q [DEPTH];
   logic [PW-1:0] wr_ptr_q, wr_ptr_d;
   logic [PW-1:0] rd_ptr_q, rd_ptr_d;
   logic [CW-1:0] count_q, count_d;
   logic          do_push;
   logic          do_pop;

   assign full_o  = (count_q == CW'(DEPTH));
   assign do_push = push_i && !full_o;
   assign do_pop  = pop_i && (count_q != '0);
   assign head_o  = mem_q[rd_ptr_q];
   assign count_o = count_q;

   // Next-state for pointers and occupancy; pointers wrap naturally since DEPTH is a power of two
   always_comb begin
      // NOTE: every output gets a default first so no path leaves a value unassigned (no latch).
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      if (do_push) wr_ptr_d = wr_ptr_q + PW'(1);
      if (do_pop)  rd_ptr_d = rd_ptr_q + PW'(1);
      case ({do_push, do_pop})
         2'b10:   count_d = count_q + CW'(1);
         2'b01:   count_d = count_q - CW'(1);
         default: count_d = count_q;
      endcase
   end

   // Control state register with synchronous reset
   always_ff @(posedge clk) begin
      // NOTE: non-blocking assignments so every flop samples pre-edge values, independent of statement order.
      if (rst) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
      end
   end

   // Entry storage
   always_ff @(posedge clk) begin
      // NOTE: storage is not reset; occupancy (count/pointers) decides which slots are meaningful.
      if (do_push) mem_q[wr_ptr_q] <= push_entry_i;
   end

   // Slot i is live when its distance from the read pointer is below the occupancy
   always_comb begin
      logic [PW-1:0] offset;
      offset = '0;
      for (int i = 0; i < DEPTH; i++) begin
         offset           = PW'(i) - rd_ptr_q;
         entry_valid_o[i] = (CW'(offset) < count_q);
         entry_addr_o[i]  = mem_q[i].addr;
      end
   end

endmodule

// File: rtl/mips_wb_queue.sv
// Write-back queue: merges ALU and load/mult-div results into the single
// register-file write port, retiring one per cycle and flagging RAW hazards.
module mips_wb_queue
   import mips_pkg::*;
#(
   parameter  int DEPTH = 4,
   localparam int CW    = $clog2(DEPTH + 1)
) (
   input  logic          CLK,
   input  logic          rst,
   input  logic          a_valid,
   output logic          a_ready,
   input  reg_addr_t     a_addr,
   input  word_t         a_data,
   input  logic          b_valid,
   output logic          b_ready,
   input  reg_addr_t     b_addr,
   input  word_t         b_data,
   output logic          RegWrite,
   output reg_addr_t     WriteAddress,
   output word_t         DataIn,
   input  reg_addr_t     hz_addr1,
   input  reg_addr_t     hz_addr2,
   output logic          hazard1,
   output logic          hazard2,
   output logic          full,
   output logic          empty,
   output logic [CW-1:0] count
);

   logic             a_fire, b_fire;
   logic             push, pop;
   wb_entry_t        push_entry, head;
   logic [DEPTH-1:0] entry_valid;
   reg_addr_t        entry_addr [DEPTH];

   logic      reg_write_q, reg_write_d;
   reg_addr_t wr_addr_q,   wr_addr_d;
   word_t     wr_data_q,   wr_data_d;

   // Accept arbitration: ALU has fixed priority, readiness comes only from registered occupancy,
   // and writes to register 0 complete the handshake without creating an entry
   always_comb begin
      a_ready    = !full;
      b_ready    = !full && !a_valid;
      a_fire     = a_valid && a_ready;
      b_fire     = b_valid && b_ready;
      push_entry = a_fire ? '{addr: a_addr, data: a_data} : '{addr: b_addr, data: b_data};
      push       = (a_fire && (a_addr != REG_ZERO)) || (b_fire && (b_addr != REG_ZERO));
   end

   assign pop = (count != '0);

   mips_wb_fifo #(.DEPTH(DEPTH)) u_fifo (
      .clk           (CLK),
      .rst           (rst),
      .push_i        (push),
      .push_entry_i  (push_entry),
      .pop_i         (pop),
      .head_o        (head),
      .count_o       (count),
      .full_o        (full),
      .entry_valid_o (entry_valid),
      .entry_addr_o  (entry_addr)
   );

   // Output stage next-state: load the head when something is queued, otherwise hold addr/data
   always_comb begin
      reg_write_d = pop;
      wr_addr_d   = wr_addr_q;
      wr_data_d   = wr_data_q;
      if (pop) begin
         wr_addr_d = head.addr;
         wr_data_d = head.data;
      end
   end

   // Output stage register; reset discards any in-flight write
   always_ff @(posedge CLK) begin
      if (rst) begin
         reg_write_q <= 1'b0;
         wr_addr_q   <= REG_ZERO;
         wr_data_q   <= '0;
      end else begin
         reg_write_q <= reg_write_d;
         wr_addr_q   <= wr_addr_d;
         wr_data_q   <= wr_data_d;
      end
   end

   assign RegWrite     = reg_write_q;
   assign WriteAddress = wr_addr_q;
   assign DataIn       = wr_data_q;
   assign empty        = (count == '0) && !reg_write_q;

   // Hazard compare over every live FIFO slot plus the output stage (commits on the next edge)
   always_comb begin
      hazard1 = reg_write_q && (wr_addr_q == hz_addr1);
      hazard2 = reg_write_q && (wr_addr_q == hz_addr2);
      for (int i = 0; i < DEPTH; i++) begin
         if (entry_valid[i] && (entry_addr[i] == hz_addr1)) hazard1 = 1'b1;
         if (entry_valid[i] && (entry_addr[i] == hz_addr2)) hazard2 = 1'b1;
      end
      if (hz_addr1 == REG_ZERO) hazard1 = 1'b0;
      if (hz_addr2 == REG_ZERO) hazard2 = 1'b0;
   end

endmodule

// File: tb/tb_mips_wb_queue.sv
// Self-checking bench for mips_wb_queue: directed vectors, corner-case
// sequences and randomized traffic against a queue-based reference model.
module tb_mips_wb_queue;
   import mips_pkg::*;

   localparam int DEPTH = 4;
   localparam int CW    = $clog2(DEPTH + 1);

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic          rst = 1'b1;
   logic          a_valid = 1'b0, b_valid = 1'b0;
   logic          a_ready, b_ready;
   reg_addr_t     a_addr = '0, b_addr = '0;
   word_t         a_data = '0, b_data = '0;
   logic          RegWrite;
   reg_addr_t     WriteAddress;
   word_t         DataIn;
   reg_addr_t     hz_addr1 = '0, hz_addr2 = '0;
   logic          hazard1, hazard2;
   logic          full, empty;
   logic [CW-1:0] count;

   mips_wb_queue #(.DEPTH(DEPTH)) dut (
      .CLK(clk), .rst(rst),
      .a_valid(a_valid), .a_ready(a_ready), .a_addr(a_addr), .a_data(a_data),
      .b_valid(b_valid), .b_ready(b_ready), .b_addr(b_addr), .b_data(b_data),
      .RegWrite(RegWrite), .WriteAddress(WriteAddress), .DataIn(DataIn),
      .hz_addr1(hz_addr1), .hz_addr2(hz_addr2), .hazard1(hazard1), .hazard2(hazard2),
      .full(full), .empty(empty), .count(count)
   );

   typedef struct {
      bit        r;
      bit        av;
      reg_addr_t aa;
      word_t     ad;
      bit        bv;
      reg_addr_t ba;
      word_t     bd;
      reg_addr_t h1;
      reg_addr_t h2;
   } stim_t;

   typedef struct packed {
      logic [4:0]  addr;
      logic [31:0] data;
   } wr_t;

   int n_checks = 0;
   int n_fail   = 0;

   // Reference model: a plain queue of pending writes plus the write being presented to the register file
   wr_t         mq[$];
   bit          m_rw = 1'b0;
   logic [4:0]  m_wa = '0;
   logic [31:0] m_di = '0;
   bit          model_valid = 1'b0;

   logic seen_h1, seen_h2, seen_ar, seen_br;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   function automatic bit m_pending(input logic [4:0] a);
      if (a == 5'd0) return 1'b0;
      if (m_rw && m_wa == a) return 1'b1;
      foreach (mq[i]) if (mq[i].addr == a) return 1'b1;
      return 1'b0;
   endfunction

   function automatic stim_t mk(bit r, bit av, reg_addr_t aa, word_t ad,
                                bit bv, reg_addr_t ba, word_t bd, reg_addr_t h1, reg_addr_t h2);
      stim_t s;
      s.r = r; s.av = av; s.aa = aa; s.ad = ad;
      s.bv = bv; s.ba = ba; s.bd = bd; s.h1 = h1; s.h2 = h2;
      return s;
   endfunction

   function automatic stim_t idle(reg_addr_t h1, reg_addr_t h2);
      return mk(0, 0, 0, 0, 0, 0, 0, h1, h2);
   endfunction

   // One clock: drive at negedge, check combinational outputs, advance model at posedge, check registers
   task automatic cycle(input stim_t s);
      bit  exp_ar, exp_br, a_acc, b_acc;
      wr_t w;
      @(negedge clk);
      rst = s.r; a_valid = s.av; a_addr = s.aa; a_data = s.ad;
      b_valid = s.bv; b_addr = s.ba; b_data = s.bd;
      hz_addr1 = s.h1; hz_addr2 = s.h2;
      #1;
      seen_h1 = hazard1; seen_h2 = hazard2; seen_ar = a_ready; seen_br = b_ready;
      exp_ar = (mq.size() < DEPTH);
      exp_br = exp_ar && !s.av;
      a_acc  = s.av && exp_ar;
      b_acc  = s.bv && exp_br;
      if (model_valid) begin
         check("a_ready", a_ready, exp_ar);
         check("b_ready", b_ready, exp_br);
         check("hazard1", hazard1, m_pending(s.h1));
         check("hazard2", hazard2, m_pending(s.h2));
         check("count_pre", count, mq.size());
         check("full_pre", full, mq.size() == DEPTH);
      end
      @(posedge clk);
      if (s.r) begin
         mq.delete();
         m_rw = 1'b0; m_wa = '0; m_di = '0;
         model_valid = 1'b1;
      end else begin
         if (mq.size() > 0) begin
            w = mq.pop_front();
            m_rw = 1'b1; m_wa = w.addr; m_di = w.data;
         end else begin
            m_rw = 1'b0;
         end
         if (a_acc && s.aa != 5'd0)      mq.push_back('{s.aa, s.ad});
         else if (b_acc && s.ba != 5'd0) mq.push_back('{s.ba, s.bd});
      end
      #1;
      if (model_valid) begin
         check("RegWrite", RegWrite, m_rw);
         check("WriteAddress", WriteAddress, m_wa);
         check("DataIn", DataIn, m_di);
         check("count", count, mq.size());
         check("empty", empty, (mq.size() == 0) && !m_rw);
         check("full", full, mq.size() == DEPTH);
         check("hazard1_post", hazard1, m_pending(s.h1));
         check("hazard2_post", hazard2, m_pending(s.h2));
      end
   endtask

   typedef struct {
      bit        use_b;
      reg_addr_t addr;
      word_t     data;
      bit        exp_write;
   } vec_t;

   initial begin
      vec_t       vecs[6];
      logic [4:0] ret[$];
      bit         exp_h[3];
      int         writes;

      vecs[0] = '{0, 5'd1,  32'hA5A5_0001, 1'b1};
      vecs[1] = '{1, 5'd31, 32'hFFFF_FFFF, 1'b1};
      vecs[2] = '{0, 5'd0,  32'h0000_1234, 1'b0};
      vecs[3] = '{1, 5'd0,  32'h0000_5678, 1'b0};
      vecs[4] = '{0, 5'd16, 32'h0000_0000, 1'b1};
      vecs[5] = '{1, 5'd2,  32'h8000_0000, 1'b1};

      // Reset held two cycles with an ALU request pending
      for (int i = 0; i < 2; i++) begin
         cycle(mk(1, 1, 5'd9, 32'h55, 0, 0, 0, 0, 0));
         check("rst_regwrite", RegWrite, 1'b0);
         check("rst_empty", empty, 1'b1);
         check("rst_count", count, 0);
      end

      // First write after release: r5 = 0x11 appears after the second edge
      cycle(mk(0, 1, 5'd5, 32'h11, 0, 0, 0, 0, 0));
      check("lat_edge1_rw", RegWrite, 1'b0);
      cycle(idle(0, 0));
      check("lat_edge2_rw", RegWrite, 1'b1);
      check("lat_edge2_wa", WriteAddress, 5'd5);
      check("lat_edge2_di", DataIn, 32'h11);
      cycle(idle(0, 0));
      check("lat_edge3_rw", RegWrite, 1'b0);

      // Table vectors: single write through either producer
      foreach (vecs[i]) begin
         if (vecs[i].use_b) cycle(mk(0, 0, 0, 0, 1, vecs[i].addr, vecs[i].data, 0, 0));
         else               cycle(mk(0, 1, vecs[i].addr, vecs[i].data, 0, 0, 0, 0, 0));
         cycle(idle(0, 0));
         check("vec_rw", RegWrite, vecs[i].exp_write);
         if (vecs[i].exp_write) begin
            check("vec_wa", WriteAddress, vecs[i].addr);
            check("vec_di", DataIn, vecs[i].data);
         end
         cycle(idle(0, 0));
         check("vec_rw_after", RegWrite, 1'b0);
      end

      // Priority: ALU wins, load/muldiv retries next cycle
      cycle(mk(0, 1, 5'd3, 32'h33, 1, 5'd4, 32'h44, 0, 0));
      check("prio_a_ready", seen_ar, 1'b1);
      check("prio_b_ready", seen_br, 1'b0);
      cycle(mk(0, 0, 0, 0, 1, 5'd4, 32'h44, 0, 0));
      check("prio_b_retry", seen_br, 1'b1);
      check("prio_first_wa", WriteAddress, 5'd3);
      cycle(idle(0, 0));
      check("prio_second_rw", RegWrite, 1'b1);
      check("prio_second_wa", WriteAddress, 5'd4);
      check("prio_second_di", DataIn, 32'h44);
      cycle(idle(0, 0));

      // Burst of six back-to-back ALU writes: nothing dropped, strict order
      for (int i = 1; i <= 6; i++) begin
         cycle(mk(0, 1, reg_addr_t'(i), 32'h100 + i, 0, 0, 0, 0, 0));
         if (RegWrite) ret.push_back(WriteAddress);
      end
      for (int i = 0; i < 3; i++) begin
         cycle(idle(0, 0));
         if (RegWrite) ret.push_back(WriteAddress);
      end
      check("burst_count", ret.size(), 6);
      foreach (ret[i]) check("burst_order", ret[i], i + 1);

      // Register 0 write is swallowed
      cycle(mk(0, 1, 5'd0, 32'hDEAD, 0, 0, 0, 0, 0));
      for (int i = 0; i < 3; i++) begin
         cycle(idle(0, 0));
         check("r0_rw", RegWrite, 1'b0);
         check("r0_count", count, 0);
         check("r0_hazard1", seen_h1, 1'b0);
      end

      // Hazard window on r7: two cycles after the accept edge, r8 never
      exp_h[0] = 1'b1; exp_h[1] = 1'b1; exp_h[2] = 1'b0;
      cycle(mk(0, 1, 5'd7, 32'h77, 0, 0, 0, 5'd7, 5'd8));
      check("hz_before_accept", seen_h1, 1'b0);
      for (int i = 0; i < 3; i++) begin
         cycle(idle(5'd7, 5'd8));
         check("hz_r7", seen_h1, exp_h[i]);
         check("hz_r8", seen_h2, 1'b0);
      end

      // Reset with writes in flight discards them
      cycle(mk(0, 1, 5'd10, 32'hA0, 0, 0, 0, 0, 0));
      cycle(mk(0, 1, 5'd11, 32'hB0, 0, 0, 0, 0, 0));
      cycle(mk(0, 1, 5'd12, 32'hC0, 0, 0, 0, 0, 0));
      cycle(mk(1, 0, 0, 0, 0, 0, 0, 0, 0));
      check("midrst_rw", RegWrite, 1'b0);
      writes = 0;
      for (int i = 0; i < 4; i++) begin
         cycle(idle(0, 0));
         if (RegWrite) writes++;
      end
      check("midrst_no_writes", writes, 0);

      // Randomized traffic against the model
      for (int i = 0; i < 600; i++) begin
         cycle(mk(($urandom_range(0, 49) == 0),
                  $urandom_range(0, 1), reg_addr_t'($urandom_range(0, 7)), word_t'($urandom),
                  $urandom_range(0, 1), reg_addr_t'($urandom_range(0, 7)), word_t'($urandom),
                  reg_addr_t'($urandom_range(0, 7)), reg_addr_t'($urandom_range(0, 7))));
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
